// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and byte-enable helper for the data-memory responder
package dmem_pkg;

    typedef enum logic [1:0] {
        SZ_B   = 2'b00,
        SZ_H   = 2'b01,
        SZ_W   = 2'b10,
        SZ_RSV = 2'b11
    } dmem_size_e;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } dmem_state_e;

    // Reserved size behaves as a word; halfwords pick their lanes from addr[1] only.
    function automatic logic [3:0] dmem_byte_en(dmem_size_e size, logic [1:0] lane);
        case (size)
            SZ_B:    return 4'b0001 << lane;
            SZ_H:    return lane[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/dmem_load_align.sv
// rtl/dmem_load_align.sv - selects the addressed byte/half of a read word and extends it to 32 bits
module dmem_load_align
    import dmem_pkg::*;
(
    input  logic [31:0] raw,
    input  logic [1:0]  lane,
    input  dmem_size_e  size,
    input  logic        is_unsigned,
    output logic [31:0] data
);

    logic [31:0] byte_sh;
    logic [31:0] half_sh;

    assign byte_sh = raw >> {lane, 3'b000};
    assign half_sh = raw >> {lane[1], 4'b0000};

    always_comb begin
        data = raw;
        case (size)
            SZ_B:    data = {{24{~is_unsigned & byte_sh[7]}}, byte_sh[7:0]};
            SZ_H:    data = {{16{~is_unsigned & half_sh[15]}}, half_sh[15:0]};
            default: data = raw;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - request/response data memory for the core load/store port
// Optional feature: define DMEM_MISALIGN_CHECK_EN to reject misaligned and reserved-size accesses.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH     = 1024,
    parameter     INIT_FILE = ""
) (
    input  logic        CLOCK,
    input  logic        RST,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [31:0]      mem [DEPTH];
    dmem_state_e      state;
    dmem_size_e       size_in;
    logic             accept;
    logic             req_bad;
    logic [IDX_W-1:0] idx;
    logic [3:0]       be;
    logic [31:0]      wlanes;
    logic [31:0]      ram_q;
    logic [31:0]      aligned;
    logic [1:0]       rd_lane;
    dmem_size_e       rd_size;
    logic             rd_uns;
    logic             rd_load;
    logic             rd_err;
    logic             unused_addr;

    assign size_in     = dmem_size_e'(req_size);
    assign req_ready   = (state == IDLE) || rsp_ready;
    assign accept      = req_valid && req_ready;
    assign idx         = req_addr[IDX_W+1:2];
    assign be          = dmem_byte_en(size_in, req_addr[1:0]);
    assign unused_addr = &{1'b0, req_addr[31:IDX_W+2]};

`ifdef DMEM_MISALIGN_CHECK_EN
    assign req_bad = ((size_in == SZ_H) && req_addr[0])
                   || ((size_in == SZ_W) && (req_addr[1:0] != 2'b00))
                   || (size_in == SZ_RSV);
`else
    assign req_bad = 1'b0;
`endif

    // Store data is right-aligned on the bus; replicate so every lane sees it.
    always_comb begin
        wlanes = req_wdata;
        case (size_in)
            SZ_B:    wlanes = {4{req_wdata[7:0]}};
            SZ_H:    wlanes = {2{req_wdata[15:0]}};
            default: wlanes = req_wdata;
        endcase
    end

    // Storage kept free of reset so it maps onto a byte-enabled block RAM.
    always_ff @(posedge CLOCK) begin
        if (accept && req_we && !req_bad) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[idx][8*b +: 8] <= wlanes[8*b +: 8];
                end
            end
        end
        if (accept) begin
            ram_q <= mem[idx];
        end
    end

    always_ff @(posedge CLOCK or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            rd_lane <= 2'b00;
            rd_size <= SZ_W;
            rd_uns  <= 1'b0;
            rd_load <= 1'b0;
            rd_err  <= 1'b0;
        end else if (accept) begin
            state   <= RESP;
            rd_lane <= req_addr[1:0];
            rd_size <= size_in;
            rd_uns  <= req_unsigned;
            rd_load <= !req_we && !req_bad;
            rd_err  <= req_bad;
        end else if (state == RESP && rsp_ready) begin
            state <= IDLE;
        end
    end

    dmem_load_align u_align (
        .raw         (ram_q),
        .lane        (rd_lane),
        .size        (rd_size),
        .is_unsigned (rd_uns),
        .data        (aligned)
    );

    // rd_load is cleared by reset, which hides the unreset RAM output register.
    assign rsp_valid = (state == RESP);
    assign rsp_rdata = rd_load ? aligned : 32'h0;
    assign rsp_err   = rd_err;

endmodule
